dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the load/store interface driven by the pipeline's access/writeback path.
- Accepts one request at a time (read, or byte/half/word store) through a valid/ready handshake.
- Performs byte-lane writes internally, so stores need no read-modify-write by the requester.
- Returns the full 32-bit word on reads; the requester does lane extraction and sign extension.

---
 rtl/dmem_responder_pkg.sv | 65 ++++++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_sp_bytewe.sv | 28 ++
 rtl/dmem_responder.sv | 96 +++++++++
 tb/tb_dmem_responder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states,
// captured-request layout and the byte-lane helpers used on stores.
package dmem_responder_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NBYTE = XLEN / 8;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic            we;
    size_e           size;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  function automatic logic [NBYTE-1:0] store_be(input size_e size, input logic [1:0] lane);
    logic [NBYTE-1:0] be;
    be = '0;
    case (size)
      SIZE_B:  be = NBYTE'(1) << lane;
      SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = '1;
      default: be = '0;
    endcase
    return be;
  endfunction

  // Right-aligned store data is replicated so every candidate lane carries it.
  function automatic logic [XLEN-1:0] store_data(input size_e size, input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] d;
    d = wdata;
    case (size)
      SIZE_B:  d = {4{wdata[7:0]}};
      SIZE_H:  d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic access_illegal(input size_e size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lane[0];
      SIZE_W:  bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store handshake between the pipeline access path (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_sp_bytewe.sv
// Single-port synchronous RAM, DEPTH x 32, per-byte write enables and a
// registered read that returns the pre-write contents of the addressed word.
module dmem_sp_bytewe
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [NBYTE-1:0] we,
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < NBYTE; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the load/store interface: one outstanding request,
// optional wait states, byte-lane stores and full-word load responses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned WAIT  = 0
) (
  input  logic             clk,
  input  logic             arst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LAST = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_e           state;
  state_e           state_nx;
  logic [3:0]       wcnt;
  req_t             cap;
  logic             rsp_load_q;
  logic             rsp_err_q;

  logic             req_err;
  logic             ram_en;
  logic [NBYTE-1:0] ram_we;
  logic [XLEN-1:0]  ram_wdata;
  logic [XLEN-1:0]  ram_rdata;

  always_comb begin
    req_err   = access_illegal(cap.size, cap.addr[1:0])
              || ({2'b00, cap.addr[XLEN-1:2]} >= 32'(DEPTH));
    // Gating with arst_n keeps a store that is reset at its ACCESS edge uncommitted.
    ram_en    = (state == ST_ACCESS) && arst_n;
    ram_we    = (cap.we && !req_err) ? store_be(cap.size, cap.addr[1:0]) : '0;
    ram_wdata = store_data(cap.size, cap.wdata);
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.req_valid) state_nx = (WAIT == 0) ? ST_ACCESS : ST_WAIT;
      ST_WAIT:   if (wcnt == WAIT_LAST) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      wcnt       <= '0;
      cap        <= '0;
      rsp_load_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.req_valid) begin
        cap.we    <= bus.req_we;
        cap.size  <= size_e'(bus.req_size);
        cap.addr  <= bus.req_addr;
        cap.wdata <= bus.req_wdata;
      end
      if (state == ST_WAIT) wcnt <= (wcnt == WAIT_LAST) ? '0 : wcnt + 4'd1;
      if (state == ST_ACCESS) begin
        rsp_load_q <= !cap.we && !req_err;
        rsp_err_q  <= req_err;
      end
    end
  end

  dmem_sp_bytewe #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (cap.addr[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register only moves on the ACCESS edge, so the masked word is
  // stable for the whole response and reads as zero after reset or on stores.
  always_comb begin
    bus.req_ready = (state == ST_IDLE) && arst_n;
    bus.rsp_valid = (state == ST_RESP);
    bus.rsp_err   = rsp_err_q;
    bus.rsp_rdata = rsp_load_q ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (WAIT=0 and WAIT=2) checked
// against a byte-addressed memory model and hand-computed expectations.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        arst_n;
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          started = 1'b0;
  int unsigned last_hs = 0;

  bit [7:0]    mb [longint];
  bit [32:0]   q0 [$];
  bit [32:0]   q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if if0 ();
  dmem_responder_if if2 ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut0 (.clk(clk), .arst_n(arst_n), .bus(if0.slave));
  dmem_responder #(.DEPTH(DEPTH), .WAIT(2)) u_dut2 (.clk(clk), .arst_n(arst_n), .bus(if2.slave));

  function automatic logic g_valid(input int d);
    return (d == 0) ? if0.rsp_valid : if2.rsp_valid;
  endfunction
  function automatic logic g_req_ready(input int d);
    return (d == 0) ? if0.req_ready : if2.req_ready;
  endfunction
  function automatic logic g_rready(input int d);
    return (d == 0) ? if0.rsp_ready : if2.rsp_ready;
  endfunction
  function automatic logic [31:0] g_rdata(input int d);
    return (d == 0) ? if0.rsp_rdata : if2.rsp_rdata;
  endfunction
  function automatic logic g_err(input int d);
    return (d == 0) ? if0.rsp_err : if2.rsp_err;
  endfunction
  function automatic int unsigned wait_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  task automatic drive_req(input int d, input logic v, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.req_valid = v; if0.req_we = we; if0.req_size = sz; if0.req_addr = a; if0.req_wdata = wd;
    end else begin
      if2.req_valid = v; if2.req_we = we; if2.req_size = sz; if2.req_addr = a; if2.req_wdata = wd;
    end
  endtask

  task automatic set_rready(input int d, input logic r);
    if (d == 0) if0.rsp_ready = r;
    else        if2.rsp_ready = r;
  endtask

  function automatic longint key(input int d, input bit [31:0] a);
    return (longint'(d) <<< 32) + longint'(a);
  endfunction

  // Memory as individually addressed bytes, little-endian within a word.
  function automatic void model_op(input int d, input bit we, input bit [1:0] sz, input bit [31:0] a,
                                   input bit [31:0] wd, output bit [31:0] r, output bit e);
    int unsigned n;
    bit [31:0]   base;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    r = '0;
    if (n == 0) e = 1'b1;
    else        e = (a % n != 0) || (a / 4 >= DEPTH);
    if (e) return;
    if (we) begin
      for (int unsigned k = 0; k < n; k++) mb[key(d, a + k)] = wd[8*k +: 8];
    end else begin
      base = a & ~32'h3;
      for (int unsigned k = 0; k < 4; k++)
        r[8*k +: 8] = mb.exists(key(d, base + k)) ? mb[key(d, base + k)] : 8'h00;
    end
  endfunction

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        if (g_valid(d)) begin
          check("req_ready_in_resp", {31'd0, g_req_ready(d)}, 32'd0);
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: dut %0d rsp_valid=1 expected 0 (t=%0t)", d, $time);
          end else begin
            bit [32:0] h;
            h = (d == 0) ? q0[0] : q1[0];
            check("rsp_rdata", g_rdata(d), h[31:0]);
            check("rsp_err", {31'd0, g_err(d)}, {31'd0, h[32]});
            if (g_rready(d)) begin
              if (d == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic flush(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic txn(input int d, input bit we, input bit [1:0] sz, input bit [31:0] a,
                     input bit [31:0] wd, input int hold, input bit b2b,
                     input bit [31:0] lit_r, input bit lit_e);
    bit [31:0]   er;
    bit          ee;
    int unsigned n;
    int unsigned lat;
    int unsigned acc;
    model_op(d, we, sz, a, wd, er, ee);
    check("model_rdata", er, lit_r);
    check("model_err", {31'd0, ee}, {31'd0, lit_e});
    if (d == 0) q0.push_back({ee, er});
    else        q1.push_back({ee, er});
    set_rready(d, 1'b0);
    drive_req(d, 1'b1, we, sz, a, wd);
    n = 0;
    @(negedge clk);
    while (!g_req_ready(d) && n < 40) begin @(negedge clk); n++; end
    if (!g_req_ready(d)) begin
      fail("accept"); drive_req(d, 1'b0, 1'b0, 2'b00, '0, '0); flush(d); return;
    end
    if (b2b) check("accept_gap", n, 0);
    @(posedge clk); #1;
    acc = cyc;
    if (b2b) check("accept_cycle", acc, last_hs + 1);
    drive_req(d, 1'b0, 1'b0, 2'b00, '0, '0);
    set_rready(d, hold == 0);
    lat = 0;
    @(negedge clk);
    while (!g_valid(d) && lat < 40) begin @(negedge clk); lat++; end
    if (!g_valid(d)) begin fail("rsp_valid"); set_rready(d, 1'b0); flush(d); return; end
    check("latency", lat, wait_of(d) + 1);
    check("rdata_lit", g_rdata(d), lit_r);
    check("err_lit", {31'd0, g_err(d)}, {31'd0, lit_e});
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 set_rready(d, 1'b1);
    end
    @(posedge clk); #1;
    last_hs = cyc;
    set_rready(d, 1'b0);
  endtask

  task automatic reset_mid_store(input int d, input bit [31:0] a, input bit [31:0] wd);
    int unsigned n;
    drive_req(d, 1'b1, 1'b1, 2'b10, a, wd);
    n = 0;
    @(negedge clk);
    while (!g_req_ready(d) && n < 40) begin @(negedge clk); n++; end
    if (!g_req_ready(d)) fail("mid_accept");
    @(posedge clk); #1;
    drive_req(d, 1'b0, 1'b0, 2'b00, '0, '0);
    arst_n = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(negedge clk);
    check("mid_req_ready", {31'd0, g_req_ready(d)}, 32'd1);
    check("mid_rsp_valid", {31'd0, g_valid(d)}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic suite(input int d);
    txn(d, 1, 2'b10, 32'h40, 32'h1234_5678, 0, 0, 32'h0, 0);
    txn(d, 0, 2'b10, 32'h40, 32'h0,         0, 1, 32'h1234_5678, 0);
    txn(d, 1, 2'b10, 32'h80, 32'hAABB_CCDD, 0, 1, 32'h0, 0);
    txn(d, 1, 2'b00, 32'h82, 32'hCAFE_0011, 0, 1, 32'h0, 0);
    txn(d, 1, 2'b01, 32'h80, 32'h5555_2233, 0, 1, 32'h0, 0);
    txn(d, 0, 2'b10, 32'h80, 32'h0,         0, 1, 32'hAA11_2233, 0);
    txn(d, 1, 2'b01, 32'h81, 32'hFFFF_FFFF, 0, 1, 32'h0, 1);
    txn(d, 1, 2'b10, 32'h42, 32'hFFFF_FFFF, 0, 1, 32'h0, 1);
    txn(d, 0, 2'b11, 32'h40, 32'h0,         0, 1, 32'h0, 1);
    txn(d, 1, 2'b10, DEPTH * 4,        32'hBADB_AD00, 0, 1, 32'h0, 1);
    txn(d, 1, 2'b10, DEPTH * 4 + 'h40, 32'hBADB_AD00, 0, 1, 32'h0, 1);
    txn(d, 0, 2'b10, DEPTH * 4,        32'h0,         0, 1, 32'h0, 1);
    txn(d, 0, 2'b00, 32'h83, 32'h0,         0, 1, 32'hAA11_2233, 0);
    txn(d, 0, 2'b10, 32'h40, 32'h0,         0, 1, 32'h1234_5678, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    set_rready(0, 1'b0);
    set_rready(1, 1'b0);
    drive_req(0, 1'b1, 1'b1, 2'b10, 32'h40, 32'hDEAD_BEEF);
    drive_req(1, 1'b1, 1'b1, 2'b10, 32'h40, 32'hDEAD_BEEF);
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("rst_req_ready", {31'd0, g_req_ready(d)}, 32'd0);
        check("rst_rsp_valid", {31'd0, g_valid(d)}, 32'd0);
        check("rst_rsp_rdata", g_rdata(d), 32'd0);
        check("rst_rsp_err", {31'd0, g_err(d)}, 32'd0);
      end
    end
    @(posedge clk); #1;
    arst_n = 1'b1;
    drive_req(0, 1'b0, 1'b0, 2'b00, '0, '0);
    drive_req(1, 1'b0, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    check("rel_req_ready0", {31'd0, g_req_ready(0)}, 32'd1);
    check("rel_req_ready2", {31'd0, g_req_ready(1)}, 32'd1);
    started = 1'b1;
    @(posedge clk); #1;

    suite(0);
    suite(1);
    txn(1, 0, 2'b10, 32'h80, 32'h0, 4, 1, 32'hAA11_2233, 0);
    txn(1, 0, 2'b10, 32'h40, 32'h0, 0, 1, 32'h1234_5678, 0);
    reset_mid_store(1, 32'h40, 32'hFFFF_0000);
    txn(1, 0, 2'b10, 32'h40, 32'h0, 0, 0, 32'h1234_5678, 0);
    txn(0, 0, 2'b10, 32'h40, 32'h0, 0, 0, 32'h1234_5678, 0);

    repeat (3) @(posedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
